// File: rtl/regfile_sb_if.sv
// Register-file bus between ID (reads, issue) and WB (writeback).
// The slave side is the register file; the master side is the pipeline.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_ready;
    logic              flush;
    logic              any_pending;

    // Issue handshake: an issue is accepted only on a cycle where iss_en and
    // iss_ready are both high; iss_en with iss_ready low is ignored and the
    // issuing stage must hold the instruction and retry.
    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, iss_ready, any_pending
    );

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, iss_ready, any_pending
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and a
// per-register in-flight write counter for RAW hazard detection.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  dec;
    logic              wr_ok;
    logic              zero_rd1, zero_rd2, zero_iss;
    logic              byp1, byp2;
    logic [CNT_W-1:0]  iss_cnt;
    logic              iss_ok;
    logic              any_cnt;

    assign zero_rd1 = (ZERO_REG != 0) && (bus.rd_addr1 == '0);
    assign zero_rd2 = (ZERO_REG != 0) && (bus.rd_addr2 == '0);
    assign zero_iss = (ZERO_REG != 0) && (bus.iss_addr == '0);
    assign wr_ok    = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Bypass is gated by rst_n so reads show zero while reset is held.
    assign byp1 = rst_n && wr_ok && (bus.wr_addr == bus.rd_addr1);
    assign byp2 = rst_n && wr_ok && (bus.wr_addr == bus.rd_addr2);

    assign bus.rd_data1 = zero_rd1 ? '0 : (byp1 ? bus.wr_data : regs[bus.rd_addr1]);
    assign bus.rd_data2 = zero_rd2 ? '0 : (byp2 ? bus.wr_data : regs[bus.rd_addr2]);

    // A writeback in the same cycle frees a slot, so a full counter can still accept.
    assign iss_cnt = cnt[bus.iss_addr];
    assign iss_ok  = zero_iss || (iss_cnt != CNT_MAX) ||
                     (bus.wr_en && (bus.wr_addr == bus.iss_addr) && (iss_cnt != '0));
    assign bus.iss_ready = iss_ok;

    always_comb begin
        inc     = '0;
        dec     = '0;
        any_cnt = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            if (bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (cnt[r] != '0))
                dec[r] = 1'b1;
            if (bus.iss_en && iss_ok && (bus.iss_addr == ADDR_W'(r)) &&
                !((ZERO_REG != 0) && (r == 0)))
                inc[r] = 1'b1;
            if (cnt[r] != '0)
                any_cnt = 1'b1;
        end
    end

    // Busy reflects the count after this cycle's writeback retires.
    assign bus.rd_busy1    = (cnt[bus.rd_addr1] - CNT_W'(dec[bus.rd_addr1])) != '0;
    assign bus.rd_busy2    = (cnt[bus.rd_addr2] - CNT_W'(dec[bus.rd_addr2])) != '0;
    assign bus.any_pending = any_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                cnt[r] <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < DEPTH; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if ((ZERO_REG != 0) && (r == 0))
                    cnt[r] <= '0;
                else if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset clear, bypass, scoreboard saturation,
// simultaneous issue/writeback, flush and underflow protection.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [DATA_W-1:0] exp_q [$];

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_b1;
        logic        e_b2;
        logic        e_rdy;
        logic        e_any;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic ie, logic [4:0] ia, logic fl,
                                logic [4:0] ra1, logic [4:0] ra2,
                                logic [31:0] e_d1, logic [31:0] e_d2,
                                logic e_b1, logic e_b2, logic e_rdy, logic e_any);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
        v.ra1 = ra1; v.ra2 = ra2; v.e_d1 = e_d1; v.e_d2 = e_d2;
        v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_rdy = e_rdy; v.e_any = e_any;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
        bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.wr_en = v.we; bus.wr_addr = v.wa; bus.wr_data = v.wd;
        bus.iss_en = v.ie; bus.iss_addr = v.ia; bus.flush = v.fl;
        bus.rd_addr1 = v.ra1; bus.rd_addr2 = v.ra2;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d rd_data1", i), bus.rd_data1, v.e_d1);
        check($sformatf("v%0d rd_data2", i), bus.rd_data2, v.e_d2);
        check($sformatf("v%0d rd_busy1", i), 32'(bus.rd_busy1), 32'(v.e_b1));
        check($sformatf("v%0d rd_busy2", i), 32'(bus.rd_busy2), 32'(v.e_b2));
        check($sformatf("v%0d iss_ready", i), 32'(bus.iss_ready), 32'(v.e_rdy));
        check($sformatf("v%0d any_pending", i), 32'(bus.any_pending), 32'(v.e_any));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive_idle();
        rst_n = 1'b0;

        // Outputs under reset, with a writeback presented that must not bypass.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEAD_BEEF;
        bus.rd_addr1 = 5'd3; bus.iss_addr = 5'd3;
        #2;
        check("reset rd_data1", bus.rd_data1, 32'h0);
        check("reset rd_busy1", 32'(bus.rd_busy1), 32'h0);
        check("reset iss_ready", 32'(bus.iss_ready), 32'h1);
        check("reset any_pending", 32'(bus.any_pending), 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill regs 1..31, checking bypass on the write cycle.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = 32'hA5A5_0000 + 32'(i);
            bus.rd_addr1 = 5'(i);
            #1;
            check($sformatf("fill bypass r%0d", i), bus.rd_data1, 32'hA5A5_0000 + 32'(i));
            exp_q.push_back(32'hA5A5_0000 + 32'(i));
        end
        @(negedge clk);
        drive_idle();
        for (int i = 1; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            #1;
            check($sformatf("readback r%0d", i), bus.rd_data1, exp_q.pop_front());
        end

        // Asynchronous reset pulse between edges clears every register at once.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("pulse iss_ready", 32'(bus.iss_ready), 32'h1);
        check("pulse any_pending", 32'(bus.any_pending), 32'h0);
        for (int i = 1; i < 32; i += 5) begin
            bus.rd_addr1 = 5'(i);
            bus.rd_addr2 = 5'(31 - i);
            #0.5;
            check($sformatf("pulse clear r%0d", i), bus.rd_data1, 32'h0);
            check($sformatf("pulse clear r%0d", 31 - i), bus.rd_data2, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();

        // we wa wd ie ia fl ra1 ra2 | d1 d2 b1 b2 rdy any
        vecs.push_back(mk(1, 8, 32'h1234_5678, 0, 0, 0, 8, 9, 32'h1234_5678, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 32'h1234_5678, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 1, 0, 0, 1));       // 4th issue ignored
        vecs.push_back(mk(0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 9, 32'h99, 0, 9, 0, 9, 0, 32'h99, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 9, 32'h98, 0, 9, 0, 9, 0, 32'h98, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 9, 32'h97, 0, 9, 0, 9, 0, 32'h97, 0, 0, 0, 1, 1)); // busy clears now
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 32'h97, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 10, 0, 10, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 10, 0, 10, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 10, 0, 10, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 10, 32'hAAAA, 1, 10, 0, 10, 0, 32'hAAAA, 0, 1, 0, 1, 1)); // issue+wb at max
        vecs.push_back(mk(0, 0, 0, 0, 10, 0, 10, 0, 32'hAAAA, 0, 1, 0, 0, 1));         // still 3
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 5, 6, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 6, 0, 5, 6, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 7, 0, 5, 6, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 12, 32'h1212, 1, 5, 1, 7, 10, 0, 32'hAAAA, 1, 1, 1, 1));  // flush
        vecs.push_back(mk(0, 0, 0, 0, 10, 0, 5, 12, 0, 32'h1212, 0, 0, 1, 0));
        vecs.push_back(mk(1, 12, 32'hC0DE, 0, 0, 0, 12, 12, 32'hC0DE, 32'hC0DE, 0, 0, 1, 0)); // cnt=0 wb
        vecs.push_back(mk(0, 0, 0, 1, 12, 0, 12, 0, 32'hC0DE, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 12, 0, 12, 0, 32'hC0DE, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 12, 32'h5151, 0, 0, 0, 12, 0, 32'h5151, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12, 0, 32'h5151, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));     // reg 0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 32'h1234_5678, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end
        @(negedge clk);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
